isa_encoder: RTL
================

# isa_encoder

Command-to-instruction encoder for the CGRA vector core. It takes compact operation descriptors from the host or control plane over a valid/ready stream and packs them into 32-bit instruction words in the exact bit layout the core's instruction decoder expects. It emits those words, each with a sequential program address, on a second valid/ready stream into instruction memory. It is the write-side counterpart of the decoder and also expands the load-immediate pseudo-op into lui/addi sequences.

## Interface
Parameters:
- dwidth_inst, 32, instruction word width (from shared include).
- dwidth_int, 32, scalar immediate width.
- ADDR_W, 10, program address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  4  operation code (package enum).
- cmd_rd  in  5  destination register (vd for vector ops, rd for scalar ops).
- cmd_rs1  in  5  source 1, base-address register, or vmv immediate.
- cmd_rs2  in  5  source 2 or vs2.
- cmd_imm  in  32  immediate: beq uses [11:0]; vsetivli uses ITR in [11:0] and VLEN in [14:12].
- cmd_last  in  1  final command of the program.
- ins_valid  out  1  instruction word valid.
- ins_ready  in  1  downstream accepts the word.
- ins_data  out  32  encoded word.
- ins_addr  out  ADDR_W  program address of ins_data.
- prog_done  out  1  one-cycle pulse after the last word is accepted.
- err  out  1  sticky illegal-op flag.

## Operation
Encodings (opcode / funct3 / other fields):
- VMACC: 0x57 / 000. [31:25]=7'h5B, vs2 [24:20], rs1 [19:15], vd [11:7].
- VLE32: 0x07 / 110. [31:25]=7'h01, rs1 base, vd.
- VSE32: 0x27 / 110. [31:25]=7'h01, rs1 base, vs3=cmd_rd.
- VMV_VI: 0x57 / 101. [31:25]=7'h2F, imm5=cmd_rs1 in [19:15], vd.
- VSETIVLI: 0x57 / 111. [31:30]=11, ITR [29:18], VLEN [17:15], [11:7]=0.
- BEQ: 0x63 / 000. rs1, rs2, imm12 scattered as {[31],[7],[30:25],[11:8]}={i[11],i[10],i[9:4],i[3:0]}.
- ADDI: 0x13 / 000. imm [31:20]=cmd_imm[11:0], rs1, rd.
- LUI: 0x37. [31:12]=cmd_imm[31:12], rd.
- CSR: 0x03 / 010. [31:20]=12'hC00, rd.
- NOP: 0x00000013.
- LI pseudo-op: writes cmd_imm into rd.
  - If cmd_imm sign-extends from 12 bits: emit `addi rd,x0,imm`.
  - Otherwise: hi=(cmd_imm+0x800)>>12, lo=cmd_imm[11:0]. Emit `lui rd,hi`, then `addi rd,rd,lo` only when lo≠0.

FSM states:
- IDLE → ONE on accepting any single-word op.
- IDLE → LUI2 on accepting an LI that needs the addi.
- LUI2 → IDLE once the addi word has been loaded into the output register.
- cmd_ready = (state==IDLE) && (!ins_valid || ins_ready).
- ONE is not a separate state: the output register holds the word.

Address and status:
- ins_addr increments by 1 on each accepted word and wraps from 2^ADDR_W−1 to 0.
- cmd_last tags the final emitted word of that command. For LI, this is the second word when one is emitted.
- When the tagged word is accepted: prog_done pulses and ins_addr returns to 0.
- Illegal cmd_op: the command is accepted and dropped, err sets, no word is emitted, and the address is unchanged. err clears only on reset.

## Timing
- Reset values: cmd_ready=0 while rst low (1 in the first cycle after release), ins_valid=0, ins_data=0, ins_addr=0, prog_done=0, err=0, state IDLE.
- Latency: command accepted at cycle T → word presented at T+1 (registered output).
- Back-to-back: one word per cycle while ins_ready=1. An LI expansion occupies two output cycles and holds cmd_ready low for one cycle.
- ins_valid must not drop, and ins_data/ins_addr must not change, until ins_ready. This is standard AXI-Stream stability.
- Backpressure in LUI2: the addi word waits until the lui word is accepted.
- Reset mid-expansion: the pending addi is discarded and the FSM returns to IDLE.
- prog_done asserts the cycle after acceptance of the last word.

## Configuration
- ISA_ENC_LI_EXPAND_EN
  - Defined: the LI pseudo-op and LUI2 state are present.
  - Undefined: LI is an illegal op (err set, command dropped), and the FSM reduces to IDLE only.

## Structure
- Shared package isa_pkg holds:
  - the cmd_op enum (VMACC, VLE32, VSE32, VMV_VI, VSETIVLI, BEQ, ADDI, LUI, CSR, NOP, LI);
  - opcode and funct3 localparams;
  - the CSR code 12'hC00.
- These constants are shared with the decoder so both sides stay consistent.
- One combinational sub-module, isa_word_pack, maps (op, fields) → 32-bit word. The encoder holds the FSM, the output register, and the address counter.

## Test plan
- VMACC vd=3 rs1=2 vs2=5 → ins_data=0xB65101D7 at ins_addr 0, one cycle after acceptance.
- VSETIVLI ITR=0x040 VLEN=3 → 0xC101F057.
- CSR rd=4 → 0xC0002203.
- LI x1,100 → single word 0x06400093.
- LI x5,0x12345FFF → 0x123462B7 then 0xFFF28293 at consecutive addresses; cmd_ready low for one cycle.
- LI x2,0x00010000 → lui only 0x00010137.
- Random ins_ready backpressure with cmd_last on the 3rd command → data stable while stalled, prog_done pulses once, next word at address 0.
- cmd_op=4'hF → err=1, no word emitted; subsequent NOP still emitted as 0x00000013.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA constants for the CGRA vector core encoder and decoder.
// Command op codes, opcode/funct fields and the CSR code live here so both sides agree.
package isa_pkg;

  typedef enum logic [3:0] {
    OP_VMACC    = 4'd0,
    OP_VLE32    = 4'd1,
    OP_VSE32    = 4'd2,
    OP_VMV_VI   = 4'd3,
    OP_VSETIVLI = 4'd4,
    OP_BEQ      = 4'd5,
    OP_ADDI     = 4'd6,
    OP_LUI      = 4'd7,
    OP_CSR      = 4'd8,
    OP_NOP      = 4'd9,
    OP_LI       = 4'd10
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LUI2 = 1'b1
  } enc_state_e;

  localparam logic [6:0] OPC_OPV     = 7'h57;
  localparam logic [6:0] OPC_VLOAD   = 7'h07;
  localparam logic [6:0] OPC_VSTORE  = 7'h27;
  localparam logic [6:0] OPC_BRANCH  = 7'h63;
  localparam logic [6:0] OPC_OPIMM   = 7'h13;
  localparam logic [6:0] OPC_LUI     = 7'h37;
  localparam logic [6:0] OPC_CSR     = 7'h03;

  localparam logic [2:0] F3_VMACC    = 3'b000;
  localparam logic [2:0] F3_VMEM32   = 3'b110;
  localparam logic [2:0] F3_VMV_VI   = 3'b101;
  localparam logic [2:0] F3_VSETIVLI = 3'b111;
  localparam logic [2:0] F3_BEQ      = 3'b000;
  localparam logic [2:0] F3_ADDI     = 3'b000;
  localparam logic [2:0] F3_CSR      = 3'b010;

  localparam logic [6:0] F7_VMACC    = 7'h5B;
  localparam logic [6:0] F7_VMEM     = 7'h01;
  localparam logic [6:0] F7_VMV      = 7'h2F;

  localparam logic [11:0] CSR_CODE   = 12'hC00;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

  // Ops that always map to exactly one word; LI is handled by the encoder.
  function automatic logic is_base_op(input logic [3:0] op);
    return op <= 4'd9;
  endfunction

endpackage

// File: rtl/isa_word_pack.sv
// Combinational packer: maps an op plus register/immediate fields to a 32-bit word.
// Ops without a single-word encoding (LI, illegal codes) produce zero.
module isa_word_pack
  import isa_pkg::*;
(
  input  op_e         op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    case (op)
      OP_VMACC:    word = {F7_VMACC, rs2, rs1, F3_VMACC, rd, OPC_OPV};
      OP_VLE32:    word = {F7_VMEM, 5'd0, rs1, F3_VMEM32, rd, OPC_VLOAD};
      OP_VSE32:    word = {F7_VMEM, 5'd0, rs1, F3_VMEM32, rd, OPC_VSTORE};
      OP_VMV_VI:   word = {F7_VMV, 5'd0, rs1, F3_VMV_VI, rd, OPC_OPV};
      // ITR in imm[11:0], VLEN in imm[14:12]
      OP_VSETIVLI: word = {2'b11, imm[11:0], imm[14:12], F3_VSETIVLI, 5'd0, OPC_OPV};
      OP_BEQ:      word = {imm[11], imm[9:4], rs2, rs1, F3_BEQ, imm[3:0], imm[10], OPC_BRANCH};
      OP_ADDI:     word = {imm[11:0], rs1, F3_ADDI, rd, OPC_OPIMM};
      OP_LUI:      word = {imm[31:12], rd, OPC_LUI};
      OP_CSR:      word = {CSR_CODE, 5'd0, F3_CSR, rd, OPC_CSR};
      OP_NOP:      word = NOP_WORD;
      default:     word = '0;
    endcase
  end

endmodule

// File: rtl/isa_encoder.sv
// Command-to-instruction encoder: registered output stream with program address counter.
// Define ISA_ENC_LI_EXPAND_EN to enable the LI pseudo-op (lui/addi expansion, LUI2 state).
//
// state   | meaning
// IDLE    | output register free or holding a word; ready for a new command
// LUI2    | lui word issued, addi word waiting for the output register
module isa_encoder
  import isa_pkg::*;
#(
  parameter int dwidth_inst = 32,
  parameter int dwidth_int  = 32,
  parameter int ADDR_W      = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic [4:0]             cmd_rd,
  input  logic [4:0]             cmd_rs1,
  input  logic [4:0]             cmd_rs2,
  input  logic [dwidth_int-1:0]  cmd_imm,
  input  logic                   cmd_last,
  output logic                   ins_valid,
  input  logic                   ins_ready,
  output logic [dwidth_inst-1:0] ins_data,
  output logic [ADDR_W-1:0]      ins_addr,
  output logic                   prog_done,
  output logic                   err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  enc_state_e  state, state_next;
  logic        out_free, out_fire, cmd_fire, cmd_legal;
  logic        load_word, word_last, ins_last;
  op_e         pk_op;
  logic [4:0]  pk_rd, pk_rs1;
  logic [31:0] pk_imm, pk_word;

  assign out_free  = !ins_valid || ins_ready;
  assign out_fire  = ins_valid && ins_ready;
  // Gate with reset so the command side never looks ready while held in reset.
  assign cmd_ready = rst && (state == ST_IDLE) && out_free;
  assign cmd_fire  = cmd_valid && cmd_ready;

`ifdef ISA_ENC_LI_EXPAND_EN
  logic [19:0] li_hi;
  logic        li_short, li_two;
  logic [4:0]  pend_rd;
  logic [11:0] pend_lo;
  logic        pend_last;

  assign cmd_legal = is_base_op(cmd_op) || (cmd_op == OP_LI);
  // Rounding by +0x800 only carries into the upper field when bit 11 is set.
  assign li_hi     = cmd_imm[31:12] + {19'd0, cmd_imm[11]};
  assign li_short  = (cmd_imm[31:11] == {21{cmd_imm[11]}});
  assign li_two    = !li_short && (cmd_imm[11:0] != 12'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_rd   <= '0;
      pend_lo   <= '0;
      pend_last <= 1'b0;
    end else if (cmd_fire && (cmd_op == OP_LI)) begin
      pend_rd   <= cmd_rd;
      pend_lo   <= cmd_imm[11:0];
      pend_last <= cmd_last;
    end
  end
`else
  assign cmd_legal = is_base_op(cmd_op);
`endif

  always_comb begin
    pk_op  = op_e'(cmd_op);
    pk_rd  = cmd_rd;
    pk_rs1 = cmd_rs1;
    pk_imm = cmd_imm;
`ifdef ISA_ENC_LI_EXPAND_EN
    if (state == ST_LUI2) begin
      pk_op  = OP_ADDI;
      pk_rd  = pend_rd;
      pk_rs1 = pend_rd;
      pk_imm = {20'd0, pend_lo};
    end else if (cmd_op == OP_LI) begin
      pk_rs1 = '0;
      if (li_short) begin
        pk_op = OP_ADDI;
      end else begin
        pk_op  = OP_LUI;
        pk_imm = {li_hi, 12'd0};
      end
    end
`endif
  end

  isa_word_pack u_pack (
    .op   (pk_op),
    .rd   (pk_rd),
    .rs1  (pk_rs1),
    .rs2  (cmd_rs2),
    .imm  (pk_imm),
    .word (pk_word)
  );

  always_comb begin
    state_next = state;
    load_word  = 1'b0;
    word_last  = cmd_last;
    case (state)
      ST_IDLE: begin
        if (cmd_fire && cmd_legal) begin
          load_word = 1'b1;
`ifdef ISA_ENC_LI_EXPAND_EN
          if ((cmd_op == OP_LI) && li_two) begin
            word_last  = 1'b0;
            state_next = ST_LUI2;
          end
`endif
        end
      end
`ifdef ISA_ENC_LI_EXPAND_EN
      ST_LUI2: begin
        word_last = pend_last;
        if (out_free) begin
          load_word  = 1'b1;
          state_next = ST_IDLE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ins_valid <= 1'b0;
      ins_data  <= '0;
      ins_addr  <= '0;
      ins_last  <= 1'b0;
      prog_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      prog_done <= out_fire && ins_last;
      if (cmd_fire && !cmd_legal) err <= 1'b1;
      // ins_addr doubles as the next-word address while the register is empty.
      if (out_fire) ins_addr <= ins_last ? '0 : ins_addr + ADDR_ONE;
      if (load_word) begin
        ins_valid <= 1'b1;
        ins_data  <= pk_word;
        ins_last  <= word_last;
      end else if (out_fire) begin
        ins_valid <= 1'b0;
      end
    end
  end

endmodule
